// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and default width.
package serial_sub_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/serial_sub_fs_bit_cell.sv
// One-bit full subtractor: d = x - y - bi (mod 2), bo is the borrow out of this bit.
module fs_bit_cell (
    input  logic x,
    input  logic y,
    input  logic bi,
    output logic d,
    output logic bo
);

    assign d  = x ^ y ^ bi;
    assign bo = (~x & bi) | (~x & y) | (y & bi);

endmodule

// File: rtl/serial_sub.sv
// Bit-serial subtractor: diff = a - b - bin, computed LSB first, one bit per clock
// through a single full-subtractor cell and a borrow flop.
module serial_sub
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int CW = $clog2(WIDTH) + 1;

    // Handshake: start is a request taken only on an edge where busy is low; while busy
    // is high start is ignored. done is a one-cycle valid with no ready: diff/bout stay
    // valid from done until the next accepted start.

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic             brw_q, brw_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;

    logic             cell_d;
    logic             cell_b;

    fs_bit_cell u_cell (
        .x  (a_sr_q[0]),
        .y  (b_sr_q[0]),
        .bi (brw_q),
        .d  (cell_d),
        .bo (cell_b)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_sr_d  = a_sr_q;
        b_sr_d  = b_sr_q;
        brw_d   = brw_q;
        diff_d  = diff_q;
        bout_d  = bout_q;
        done_d  = 1'b0;
        busy_d  = busy_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_sr_d  = a;
                    b_sr_d  = b;
                    brw_d   = bin;
                    cnt_d   = '0;
                    state_d = SHIFT;
                    busy_d  = 1'b1;
                end
            end
            SHIFT: begin
                // Result bits enter at the MSB so the LSB lands at bit 0 after WIDTH shifts.
                diff_d = {cell_d, diff_q[WIDTH-1:1]};
                brw_d  = cell_b;
                a_sr_d = a_sr_q >> 1;
                b_sr_d = b_sr_q >> 1;
                cnt_d  = cnt_q + CW'(1);
                busy_d = 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    bout_d  = cell_b;
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_sr_q  <= '0;
            b_sr_q  <= '0;
            brw_q   <= 1'b0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_sr_q  <= a_sr_d;
            b_sr_q  <= b_sr_d;
            brw_q   <= brw_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign diff = diff_q;
    assign bout = bout_q;

endmodule

// File: tb/tb_serial_sub.sv
// Directed bench for serial_sub: an 8-bit instance for the hand-computed vectors and
// control scenarios, and a 4-bit instance swept exhaustively against an arithmetic model.
module tb_serial_sub;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic       start8 = 1'b0;
    logic [7:0] a8 = '0;
    logic [7:0] b8 = '0;
    logic       bin8 = 1'b0;
    logic       busy8, done8, bout8;
    logic [7:0] diff8;

    logic       start4 = 1'b0;
    logic [3:0] a4 = '0;
    logic [3:0] b4 = '0;
    logic       bin4 = 1'b0;
    logic       busy4, done4, bout4;
    logic [3:0] diff4;

    int n_checks = 0;
    int n_pass = 0;

    logic [4:0] exp_q[$];

    always #5 clk = ~clk;

    serial_sub #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start8),
        .a     (a8),
        .b     (b8),
        .bin   (bin8),
        .busy  (busy8),
        .done  (done8),
        .diff  (diff8),
        .bout  (bout8)
    );

    serial_sub #(.WIDTH(4)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start4),
        .a     (a4),
        .b     (b4),
        .bin   (bin4),
        .busy  (busy4),
        .done  (done4),
        .diff  (diff4),
        .bout  (bout4)
    );

    // Called at a negedge; returns at the negedge where done8 is seen (lat = edges from
    // the accepting edge inclusive, -1 on timeout). Operands are scrambled after acceptance.
    task automatic run_op8(input logic [7:0] ta, input logic [7:0] tb, input logic tbin,
                           output logic [7:0] rd, output logic rb, output int lat);
        start8 = 1'b1;
        a8 = ta;
        b8 = tb;
        bin8 = tbin;
        rd = '0;
        rb = 1'b0;
        lat = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            start8 = 1'b0;
            a8 = 8'($urandom);
            b8 = 8'($urandom);
            bin8 = 1'($urandom);
            if (done8) begin
                rd = diff8;
                rb = bout8;
                return;
            end
        end
        lat = -1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({busy8, done8, diff8, bout8} !== 11'b0) begin
            $display("FAIL reset_w8: busy=%b done=%b diff=%h bout=%b, required all 0",
                     busy8, done8, diff8, bout8);
        end else n_pass++;
        n_checks++;
        if ({busy4, done4, diff4, bout4} !== 7'b0) begin
            $display("FAIL reset_w4: busy=%b done=%b diff=%h bout=%b, required all 0",
                     busy4, done4, diff4, bout4);
        end else n_pass++;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_vectors();
        logic [7:0] va[5] = '{8'h05, 8'h03, 8'h00, 8'hFF, 8'h80};
        logic [7:0] vb[5] = '{8'h03, 8'h05, 8'h00, 8'hFF, 8'h01};
        logic       vc[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        logic [7:0] vd[5] = '{8'h02, 8'hFE, 8'hFF, 8'hFF, 8'h7F};
        logic       vo[5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [7:0] rd;
        logic       rb;
        int         lat;
        logic       hold_ok;
        for (int v = 0; v < 5; v++) begin
            run_op8(va[v], vb[v], vc[v], rd, rb, lat);
            n_checks++;
            if (lat !== 9) $display("FAIL latency_v%0d: got %0d edges, required 9", v, lat);
            else n_pass++;
            n_checks++;
            if (rd !== vd[v]) $display("FAIL diff_v%0d: got %h, required %h", v, rd, vd[v]);
            else n_pass++;
            n_checks++;
            if (rb !== vo[v]) $display("FAIL bout_v%0d: got %b, required %b", v, rb, vo[v]);
            else n_pass++;
            hold_ok = 1'b1;
            repeat (3) begin
                @(negedge clk);
                if (done8 !== 1'b0 || busy8 !== 1'b0 || diff8 !== vd[v] || bout8 !== vo[v])
                    hold_ok = 1'b0;
            end
            n_checks++;
            if (!hold_ok)
                $display("FAIL hold_v%0d: done=%b busy=%b diff=%h bout=%b, required 0 0 %h %b",
                         v, done8, busy8, diff8, bout8, vd[v], vo[v]);
            else n_pass++;
        end
    endtask

    task automatic test_ignored_start();
        int         lat = 0;
        int         ndone = 0;
        int         done_lat = -1;
        logic [7:0] first_diff = '0;
        logic       first_bout = 1'b1;
        start8 = 1'b1;
        a8 = 8'h5A;
        b8 = 8'h33;
        bin8 = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (lat == 3) begin
                start8 = 1'b1;
                a8 = 8'hFF;
                b8 = 8'h00;
                bin8 = 1'b1;
            end else begin
                start8 = 1'b0;
                a8 = 8'h00;
                b8 = 8'h00;
                bin8 = 1'b0;
            end
            if (done8) begin
                ndone++;
                if (done_lat < 0) begin
                    done_lat = lat;
                    first_diff = diff8;
                    first_bout = bout8;
                end
            end
        end
        n_checks++;
        if (ndone !== 1) $display("FAIL ignored_done_count: got %0d pulses, required 1", ndone);
        else n_pass++;
        n_checks++;
        if (done_lat !== 9) $display("FAIL ignored_latency: got %0d edges, required 9", done_lat);
        else n_pass++;
        n_checks++;
        if (first_diff !== 8'h27 || first_bout !== 1'b0)
            $display("FAIL ignored_result: got diff=%h bout=%b, required 27 0", first_diff, first_bout);
        else n_pass++;
        n_checks++;
        if (busy8 !== 1'b0 || diff8 !== 8'h27)
            $display("FAIL ignored_after: busy=%b diff=%h, required 0 27", busy8, diff8);
        else n_pass++;
    endtask

    task automatic test_reset_abort();
        int         ndone = 0;
        logic [7:0] rd;
        logic       rb;
        int         lat;
        start8 = 1'b1;
        a8 = 8'hC3;
        b8 = 8'h11;
        bin8 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            @(negedge clk);
            start8 = 1'b0;
        end
        n_checks++;
        if (busy8 !== 1'b1) $display("FAIL abort_busy_before: got %b, required 1", busy8);
        else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({busy8, done8, diff8, bout8} !== 11'b0)
            $display("FAIL abort_async: busy=%b done=%b diff=%h bout=%b, required all 0",
                     busy8, done8, diff8, bout8);
        else n_pass++;
        repeat (2) begin
            @(negedge clk);
            if (done8) ndone++;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done8) ndone++;
        end
        n_checks++;
        if (ndone !== 0) $display("FAIL abort_no_done: got %0d pulses, required 0", ndone);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        run_op8(8'h64, 8'h1E, 1'b1, rd, rb, lat);
        n_checks++;
        if (lat !== 9 || rd !== 8'h45 || rb !== 1'b0)
            $display("FAIL abort_recover: lat=%0d diff=%h bout=%b, required 9 45 0", lat, rd, rb);
        else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_sweep4();
        logic [4:0] exp_v;
        logic [4:0] got_v;
        int         lat;
        for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
                for (int ic = 0; ic < 2; ic++) begin
                    start4 = 1'b1;
                    a4 = 4'(ia);
                    b4 = 4'(ib);
                    bin4 = 1'(ic);
                    exp_v[3:0] = 4'(ia - ib - ic);
                    exp_v[4] = (ia < ib + ic);
                    exp_q.push_back(exp_v);
                    lat = -1;
                    for (int i = 1; i <= 12; i++) begin
                        @(posedge clk);
                        @(negedge clk);
                        start4 = 1'b0;
                        a4 = 4'($urandom_range(0, 15));
                        b4 = 4'($urandom_range(0, 15));
                        bin4 = 1'($urandom_range(0, 1));
                        if (done4) begin
                            lat = i;
                            break;
                        end
                    end
                    exp_v = exp_q.pop_front();
                    got_v = {bout4, diff4};
                    n_checks++;
                    if (lat !== 5)
                        $display("FAIL sweep_latency a=%0d b=%0d bin=%0d: got %0d, required 5",
                                 ia, ib, ic, lat);
                    else n_pass++;
                    n_checks++;
                    if (got_v !== exp_v)
                        $display("FAIL sweep_result a=%0d b=%0d bin=%0d: got bout=%b diff=%h, required bout=%b diff=%h",
                                 ia, ib, ic, got_v[4], got_v[3:0], exp_v[4], exp_v[3:0]);
                    else n_pass++;
                    @(negedge clk);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_ignored_start();
        test_reset_abort();
        test_sweep4();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/serial_sub.md
SERIAL_SUB -- requirements
Module: serial_sub

Interface
REQ-001 Parameter: WIDTH, default 8, operand/result width in bits (legal range 2..32).
REQ-002 Port: clk  input  1  single clock, all state updates on rising edge.
REQ-003 Port: rst_n  input  1  asynchronous active-low reset.
REQ-004 Port: start  input  1  request a new subtraction; sampled only in IDLE.
REQ-005 Port: a  input  WIDTH  minuend, captured on accepted start.
REQ-006 Port: b  input  WIDTH  subtrahend, captured on accepted start.
REQ-007 Port: bin  input  1  borrow-in, captured on accepted start.
REQ-008 Port: busy  output  1  high while a subtraction is in progress (SHIFT and DONE states).
REQ-009 Port: done  output  1  single-cycle pulse marking diff/bout valid.
REQ-010 Port: diff  output  WIDTH  result a - b - bin, modulo 2^WIDTH.
REQ-011 Port: bout  output  1  final borrow-out; 1 when a < b + bin (unsigned).

Function
REQ-012 The block SHALL be a bit-serial subtractor: one full-subtractor cell plus a borrow flip-flop, LSB first, one bit per clock.
REQ-013 FSM states SHALL be IDLE, SHIFT, DONE.
REQ-014 IDLE + start=1: load a and b into shift registers, borrow flop <= bin, bit counter <= 0, go to SHIFT.
REQ-015 IDLE + start=0: stay in IDLE; diff and bout hold their last values.
REQ-016 SHIFT, each cycle: cell inputs = a_sr[0], b_sr[0], borrow flop; D bit shifts into diff register at the MSB end (diff shifts right); borrow flop <= cell borrow; a_sr and b_sr shift right; counter increments.
REQ-017 SHIFT SHALL last exactly WIDTH cycles; on the cycle the counter reaches WIDTH-1, go to DONE.
REQ-018 Cell equations: D = x ^ y ^ bi; B = (~x & bi) | (~x & y) | (y & bi).
REQ-019 DONE: done=1 for exactly one cycle, bout = borrow flop, diff = full result; next state IDLE unconditionally.
REQ-020 Latency: start accepted at edge N implies done high during cycle N+WIDTH+1 (WIDTH+1 cycles from start to done).
REQ-021 start while busy=1 (SHIFT or DONE) SHALL be ignored, with no effect on operands or counter.
REQ-022 diff and bout SHALL be stable from done until the next accepted start; they are undefined-but-deterministic during SHIFT (partial values visible).
REQ-023 Counter width SHALL be $clog2(WIDTH)+1 bits; no wrap occurs within one operation.
REQ-024 Operand inputs a, b, bin SHALL be don't-care except on the accepting edge.

Reset
REQ-025 rst_n low SHALL asynchronously force state=IDLE, busy=0, done=0, diff=0, bout=0, counter=0, shift registers=0, borrow flop=0.
REQ-026 Reset asserted mid-operation SHALL abort it with no done pulse; after release the block is in IDLE and accepts start on the first rising edge with rst_n high.

Structure
REQ-027 A shared package SHALL hold the FSM state enum (IDLE, SHIFT, DONE) and the default WIDTH constant.
REQ-028 One sub-module SHALL be instantiated: fs_bit_cell, a purely combinational 1-bit full subtractor implementing REQ-018.
REQ-029 All sequential logic SHALL reside in serial_sub; fs_bit_cell SHALL contain no state.

Verification
REQ-030 WIDTH=8, a=5, b=3, bin=0 -> done after 9 cycles, diff=8'h02, bout=0.
REQ-031 a=3, b=5, bin=0 -> diff=8'hFE, bout=1; a=0, b=0, bin=1 -> diff=8'hFF, bout=1.
REQ-032 a=8'hFF, b=8'hFF, bin=1 -> diff=8'hFF, bout=1; a=8'h80, b=8'h01, bin=0 -> diff=8'h7F, bout=0.
REQ-033 start pulsed again 3 cycles after the first accepted start, with different operands -> ignored; first result delivered unchanged at cycle 9, and exactly one done pulse.
REQ-034 rst_n driven low 4 cycles into SHIFT -> busy, done, diff and bout all 0 immediately; no done pulse; the next start yields a correct result.
REQ-035 Exhaustive WIDTH=4 sweep over all a, b, bin -> diff and bout match the (a - b - bin) reference model on every done pulse.
